// File: rtl/lmc_pkg.sv
// Shared definitions for the Little-Man-Computer core: opcode values and FSM states.
package lmc_pkg;

  localparam int unsigned OP_HLT = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_SUB = 2;
  localparam int unsigned OP_STA = 3;
  localparam int unsigned OP_LDA = 4;
  localparam int unsigned OP_BRA = 5;
  localparam int unsigned OP_BRZ = 6;
  localparam int unsigned OP_BRP = 7;
  localparam int unsigned OP_INP = 8;
  localparam int unsigned OP_OUT = 9;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT
  } state_t;

endpackage

// File: rtl/lmc_ram.sv
// Unified program/data memory: one synchronous write port, one asynchronous read port.
module lmc_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lmc_core.sv
// Little-Man-Computer core: fetch/execute FSM, PC, IR, ACC and ALU around a shared RAM.
module lmc_core
  import lmc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  timer555,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  int unsigned           op;
  logic [ADDR_WIDTH-1:0] operand_addr;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    op           = 32'(ir[DATA_WIDTH-1:ADDR_WIDTH]);
    operand_addr = ir[ADDR_WIDTH-1:0];
  end

  // Loader owns the write port while halted; STA owns it during EXEC.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    if (state == S_HALT) begin
      ram_we = prog_we;
    end else if (state == S_EXEC && op == OP_STA) begin
      ram_we    = 1'b1;
      ram_waddr = operand_addr;
      ram_wdata = acc_q;
    end
  end

  assign ram_raddr = (state == S_FETCH) ? pc_q : operand_addr;

  lmc_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (timer555),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge timer555) begin
    if (reset) state <= S_HALT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HALT:     if (start) state_next = S_FETCH;
      S_FETCH:    state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_HLT:  state_next = S_HALT;
          OP_INP:  state_next = S_WAIT_IN;
          OP_OUT:  state_next = S_WAIT_OUT;
          default: state_next = S_FETCH;
        endcase
      end
      S_WAIT_IN:  if (in_valid) state_next = S_FETCH;
      S_WAIT_OUT: if (out_ready) state_next = S_FETCH;
      default:    state_next = S_HALT;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_WAIT_IN);
    out_valid = (state == S_WAIT_OUT);
    halted    = (state == S_HALT);
  end

  always_ff @(posedge timer555) begin
    if (reset) begin
      pc_q  <= '0;
      acc_q <= '0;
      ir    <= '0;
      out_q <= '0;
    end else begin
      case (state)
        S_HALT: begin
          if (start) begin
            pc_q  <= '0;
            acc_q <= '0;
          end
        end
        S_FETCH: begin
          ir   <= ram_rdata;
          pc_q <= pc_q + PC_ONE;
        end
        S_EXEC: begin
          case (op)
            OP_ADD: acc_q <= acc_q + ram_rdata;
            OP_SUB: acc_q <= acc_q - ram_rdata;
            OP_LDA: acc_q <= ram_rdata;
            OP_BRA: pc_q  <= operand_addr;
            OP_BRZ: if (acc_q == '0) pc_q <= operand_addr;
            OP_BRP: if (!acc_q[DATA_WIDTH-1]) pc_q <= operand_addr;
            OP_OUT: out_q <= acc_q;
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (in_valid) acc_q <= in_data;
        end
        default: ;
      endcase
    end
  end

  assign acc      = acc_q;
  assign pc       = pc_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_lmc_core.sv
// Randomized self-checking bench for lmc_core against an instruction-level LMC model.
module tb_lmc_core;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int M_HALT = 0, M_FETCH = 1, M_EXEC = 2, M_IN = 3, M_OUT = 4;

  logic          timer555 = 1'b0;
  logic          reset, start, prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data, in_data, out_data, acc;
  logic          in_valid, in_ready, out_valid, out_ready, halted;
  logic [AW-1:0] pc;

  always #5 timer555 = ~timer555;

  lmc_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .timer555 (timer555),
    .reset    (reset),
    .start    (start),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc      (acc),
    .pc       (pc),
    .halted   (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Reference machine: one LMC instruction = fetch cycle, execute cycle, optional IO wait.
  int m_mode, m_pc, m_acc, m_ir, m_od;
  int m_mem[16];
  int m_outs[$];
  int in_q[$];
  int dut_outs[$];
  bit chk_en = 1'b0;

  always @(posedge timer555) begin
    int op, a, v;
    if (reset) begin
      m_mode = M_HALT; m_pc = 0; m_acc = 0; m_ir = 0; m_od = 0;
    end else begin
      case (m_mode)
        M_HALT: begin
          if (prog_we) m_mem[int'(prog_addr)] = int'(prog_data);
          if (start) begin m_pc = 0; m_acc = 0; m_mode = M_FETCH; end
        end
        M_FETCH: begin
          m_ir   = m_mem[m_pc];
          m_pc   = (m_pc + 1) % 16;
          m_mode = M_EXEC;
        end
        M_EXEC: begin
          op = m_ir / 16;
          a  = m_ir % 16;
          v  = m_mem[a];
          m_mode = M_FETCH;
          case (op)
            0: m_mode = M_HALT;
            1: m_acc = (m_acc + v) % 256;
            2: m_acc = (m_acc - v + 256) % 256;
            3: m_mem[a] = m_acc;
            4: m_acc = v;
            5: m_pc = a;
            6: if (m_acc == 0) m_pc = a;
            7: if (m_acc < 128) m_pc = a;
            8: m_mode = M_IN;
            9: begin m_od = m_acc; m_mode = M_OUT; end
            default: ;
          endcase
        end
        M_IN: begin
          if (in_valid) begin
            m_acc = int'(in_data);
            if (in_q.size() > 0) void'(in_q.pop_front());
            m_mode = M_FETCH;
          end
        end
        M_OUT: begin
          if (out_ready) begin
            m_outs.push_back(m_od);
            m_mode = M_FETCH;
          end
        end
        default: m_mode = M_HALT;
      endcase
    end
  end

  always @(posedge timer555) begin
    if (!reset && out_valid && out_ready) dut_outs.push_back(int'(out_data));
  end

  always @(posedge timer555) begin
    #1;
    if (chk_en) begin
      chk("halted",    int'(halted),    int'(m_mode == M_HALT));
      chk("in_ready",  int'(in_ready),  int'(m_mode == M_IN));
      chk("out_valid", int'(out_valid), int'(m_mode == M_OUT));
      chk("pc",        int'(pc),        m_pc);
      chk("acc",       int'(acc),       m_acc);
      chk("out_data",  int'(out_data),  m_od);
    end
  end

  int prog[16];
  int hold_valid, hold_data, hold_pc;

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge timer555);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 8'(prog[i]);
    end
    @(negedge timer555);
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge timer555); reset = 1'b1;
    @(negedge timer555); reset = 1'b0;
  endtask

  task automatic run_prog(input int max_cyc, input bit we_noise, input bit we0,
                          input int w0, input int hold, output bit done);
    int held;
    held = 0; done = 1'b0;
    hold_valid = -1; hold_data = -1; hold_pc = -1;
    m_outs.delete(); dut_outs.delete();
    @(negedge timer555);
    start = 1'b1;
    if (we0) begin prog_we = 1'b1; prog_addr = '0; prog_data = 8'(w0); end
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge timer555);
      start = 1'b0; prog_we = 1'b0;
      if (m_mode == M_HALT) begin done = 1'b1; break; end
      in_valid  = 1'($urandom % 2);
      in_data   = (in_q.size() > 0) ? 8'(in_q[0]) : 8'($urandom);
      out_ready = 1'($urandom % 2);
      if (m_mode == M_OUT && held < hold) begin
        out_ready = 1'b0;
        held++;
        if (held == hold) begin
          hold_valid = int'(out_valid); hold_data = int'(out_data); hold_pc = int'(pc);
        end
      end
      if ($urandom % 4 == 0) start = 1'b1;
      if (we_noise && ($urandom % 2 == 1)) begin
        prog_we = 1'b1; prog_addr = 4'hE; prog_data = 8'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit done;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge timer555);
    chk("rst_halted",    int'(halted),    1);
    chk("rst_pc",        int'(pc),        0);
    chk("rst_acc",       int'(acc),       0);
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Sum of two inputs.
    prog = '{'h80, 'h3F, 'h80, 'h1F, 'h90, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    in_q = '{5, 7};
    load_prog();
    run_prog(300, 1'b0, 1'b0, 0, 0, done);
    chk("sum_done",      int'(done), 1);
    chk("sum_nout",      dut_outs.size(), 1);
    chk("sum_out",       q_at(dut_outs, 0), 'h0C);
    chk("sum_model_out", q_at(m_outs, 0), 'h0C);
    chk("sum_pc",        int'(pc), 6);
    chk("sum_model_memf", m_mem[15], 5);

    // ADD wrap, SUB to zero with BRZ taken, BRP on negative not taken.
    prog = '{'h80, 'h1E, 'h90, 'h2D, 'h67, 'h90, 'h00, 'h4C,
             'h7B, 'h90, 'h00, 'h90, 'h80, 'h10, 'h20, 'h00};
    in_q = '{'hF0};
    load_prog();
    run_prog(300, 1'b0, 1'b0, 0, 0, done);
    chk("alu_done", int'(done), 1);
    chk("alu_nout", dut_outs.size(), 2);
    chk("alu_out0", q_at(dut_outs, 0), 'h10);
    chk("alu_out1", q_at(dut_outs, 1), 'h80);
    chk("alu_acc",  int'(acc), 'h80);
    chk("alu_pc",   int'(pc), 'hB);

    // OUT back-pressure held for 10 cycles.
    prog = '{'h4F, 'h90, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A};
    in_q.delete();
    load_prog();
    run_prog(300, 1'b0, 1'b0, 0, 10, done);
    chk("hold_done",  int'(done), 1);
    chk("hold_valid", hold_valid, 1);
    chk("hold_data",  hold_data, 'h5A);
    chk("hold_pc",    hold_pc, 2);
    chk("hold_out",   q_at(dut_outs, 0), 'h5A);

    // Loader writes while running are ignored; rerun reads the word back.
    prog = '{'h4E, 'h90, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33, 0};
    load_prog();
    run_prog(300, 1'b1, 1'b0, 0, 0, done);
    chk("we_run_out", q_at(dut_outs, 0), 'h33);
    run_prog(300, 1'b0, 1'b0, 0, 0, done);
    chk("we_readback", q_at(dut_outs, 0), 'h33);
    chk("we_model_mem", m_mem[14], 'h33);

    // Write and start in the same halted cycle: the new word 0 runs.
    prog = '{'h00, 'h90, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h77, 0, 0};
    load_prog();
    run_prog(300, 1'b0, 1'b1, 'h4D, 0, done);
    chk("ws_nout", dut_outs.size(), 1);
    chk("ws_out",  q_at(dut_outs, 0), 'h77);

    // BRZ/BRA to the top of memory; fetch at F wraps PC to 0.
    prog = '{'h6E, 'h90, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5F, 'h10};
    load_prog();
    run_prog(300, 1'b0, 1'b0, 0, 0, done);
    chk("wrap_out", q_at(dut_outs, 0), 'h6E);
    chk("wrap_pc",  int'(pc), 3);

    // Countdown loop with SUB/BRP.
    prog = '{'h80, 'h2E, 'h90, 'h71, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h01, 0};
    in_q = '{3};
    load_prog();
    run_prog(500, 1'b0, 1'b0, 0, 0, done);
    chk("cnt_done", int'(done), 1);
    chk("cnt_nout", dut_outs.size(), 4);
    chk("cnt_out0", q_at(dut_outs, 0), 2);
    chk("cnt_out3", q_at(dut_outs, 3), 'hFF);
    chk("cnt_pc",   int'(pc), 5);

    // Reset while waiting for input with in_valid high.
    prog = '{'h4F, 'h80, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h09};
    in_q.delete();
    load_prog();
    @(negedge timer555); start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge timer555); start = 1'b0;
      if (m_mode == M_IN) break;
    end
    chk("rin_ready_pre", int'(in_ready), 1);
    chk("rin_acc_pre",   int'(acc), 9);
    in_valid = 1'b1; in_data = 8'h55; reset = 1'b1;
    @(posedge timer555); #1;
    chk("rin_acc",      int'(acc), 0);
    chk("rin_halted",   int'(halted), 1);
    chk("rin_in_ready", int'(in_ready), 0);
    @(negedge timer555); reset = 1'b0; in_valid = 1'b0;

    // Random programs; runaway loops are stopped with reset.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) prog[i] = int'($urandom % 256);
      in_q.delete();
      load_prog();
      run_prog(300, 1'b0, 1'b0, 0, 0, done);
      if (!done) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
